// File: rtl/lsu.sv
// Load/store unit: turns ALU address + rs2 into a request/ready data-memory access,
// stalls the core while the access is in flight and returns an extended load value.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          to_q, to_d;

    logic          req;
    logic          fault;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_val;

    // Request decode: size faults and illegal codes both report as misaligned.
    always_comb begin
        req   = mem_read | mem_write;
        fault = 1'b0;
        if (mem_read && mem_write)
            fault = 1'b1;
        else if (mem_read && ((funct3[1:0] == 2'b11) || (funct3[2] && funct3[1])))
            fault = 1'b1;
        else if (mem_write && ((funct3[1:0] == 2'b11) || funct3[2]))
            fault = 1'b1;
        else if ((funct3[1:0] == 2'b01) && addr[0])
            fault = 1'b1;
        else if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
            fault = 1'b1;

        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
        ld_half = bus_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'b0, ld_byte};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        to_d     = to_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    rdata_d = '0;
                    to_d    = 1'b0;
                    if (fault) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mis_d    = 1'b0;
                        we_d     = mem_write;
                        addr_d   = {addr[31:2], 2'b00};
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        funct3_d = funct3;
                        off_d    = addr[1:0];
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    rdata_d = we_q ? '0 : ld_val;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            to_q     <= to_d;
        end
    end

    // bus_req decodes from state so an async reset drops it without a clock edge.
    assign stall       = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign done        = (state_q == DONE);
    assign misaligned  = (state_q == DONE) && mis_q;
    assign bus_timeout = (state_q == DONE) && to_q;
    assign rdata       = rdata_q;
    assign bus_req     = (state_q == BUSY);
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu, checked against a per-access reference model.
module tb_lsu;
    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned, bus_timeout;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .done(done), .misaligned(misaligned), .bus_timeout(bus_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned off,
                                             input logic [31:0] w);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Drives one instruction; delay = BUSY cycles with bus_ready low before it rises.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rw, input int unsigned delay,
                             input string name);
        int unsigned off, size, exp_stalls, exp_req, stalls, reqs;
        bit          legal, exp_fault, exp_to, got_done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        off  = a % 4;
        size = f3 % 4;
        if (rd && !wr)      legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else if (wr && !rd) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else                legal = 0;
        exp_fault = !legal || (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
        exp_be = (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'hF;
        exp_wd = (size == 0) ? {4{wd[7:0]}} : (size == 1) ? {2{wd[15:0]}} : wd;
        exp_to = !exp_fault && delay >= T;
        if (exp_fault)       begin exp_stalls = 1;         exp_req = 0;         end
        else if (delay < T)  begin exp_stalls = delay + 2; exp_req = delay + 1; end
        else                 begin exp_stalls = T + 1;     exp_req = T;         end
        exp_rd = (exp_fault || exp_to || wr) ? 32'h0 : ref_load(f3, off, rw);

        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        stalls = 0; reqs = 0; got_done = 0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(negedge clk);
            if (bus_req) begin
                reqs++;
                checks++;
                if (exp_fault || bus_we !== wr || bus_addr !== {a[31:2], 2'b00} ||
                    bus_be !== exp_be || (wr && bus_wdata !== exp_wd)) begin
                    errors++;
                    $display("FAIL %s bus fields: req=%0d we=%b addr=%h be=%b wd=%h, expected we=%b addr=%h be=%b wd=%h fault=%0d",
                             name, reqs, bus_we, bus_addr, bus_be, bus_wdata, wr,
                             {a[31:2], 2'b00}, exp_be, exp_wd, exp_fault);
                end
                bus_ready = (reqs - 1 == delay);
                bus_rdata = rw;
            end else begin
                bus_ready = 1'($urandom);
                bus_rdata = $urandom;
            end
            if (done) begin
                got_done = 1;
                checks++;
                if (stall !== 1'b0 || rdata !== exp_rd || misaligned !== exp_fault ||
                    bus_timeout !== exp_to || stalls != exp_stalls || reqs != exp_req) begin
                    errors++;
                    $display("FAIL %s completion: stall=%b rdata=%h mis=%b to=%b stalls=%0d reqs=%0d, expected stall=0 rdata=%h mis=%b to=%b stalls=%0d reqs=%0d",
                             name, stall, rdata, misaligned, bus_timeout, stalls, reqs,
                             exp_rd, exp_fault, exp_to, exp_stalls, exp_req);
                end
            end else begin
                stalls++;
                checks++;
                if (stall !== 1'b1 || misaligned !== 1'b0 || bus_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in-flight: stall=%b mis=%b to=%b, expected stall=1 flags=0",
                             name, stall, misaligned, bus_timeout);
                end
            end
            @(posedge clk);
            #1;
        end
        mem_read = 0; mem_write = 0; bus_ready = 0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s no done within cycle budget", name);
        end
    endtask

    task automatic test_reset;
        rst = 1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_ready = 0; bus_rdata = 0;
        #1;
        checks++;
        if ({stall, done, misaligned, bus_timeout, bus_req, bus_we} !== 6'b0 ||
            bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0 || rdata !== 0) begin
            errors++;
            $display("FAIL reset values: stall=%b done=%b mis=%b to=%b req=%b we=%b addr=%h be=%b wd=%h rdata=%h, expected all 0",
                     stall, done, misaligned, bus_timeout, bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle quiet: stall=%b req=%b done=%b, expected 0", stall, bus_req, done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load;
        do_access(1, 0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1, "lw_delay");
    endtask

    task automatic test_byte_load;
        do_access(1, 0, 3'b000, 32'h0000_2003, 32'h0, 32'h8011_2233, 0, "lb");
        do_access(1, 0, 3'b100, 32'h0000_2003, 32'h0, 32'h8011_2233, 0, "lbu");
        do_access(1, 0, 3'b001, 32'h0000_2002, 32'h0, 32'h8011_2233, 2, "lh_hi");
        do_access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h8011_2233, 0, "lhu_hi");
    endtask

    task automatic test_store;
        do_access(0, 1, 3'b000, 32'h0000_3002, 32'h1234_5678, 32'hFFFF_FFFF, 0, "sb");
        do_access(0, 1, 3'b001, 32'h0000_3002, 32'h1234_5678, 32'hFFFF_FFFF, 1, "sh");
        do_access(0, 1, 3'b010, 32'h0000_3004, 32'h1234_5678, 32'hFFFF_FFFF, 0, "sw");
    endtask

    task automatic test_faults;
        do_access(1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h1, 0, "lw_misaligned");
        do_access(1, 0, 3'b001, 32'h0000_1001, 32'h0, 32'h1, 0, "lh_misaligned");
        do_access(0, 1, 3'b010, 32'h0000_1003, 32'h5, 32'h1, 0, "sw_misaligned");
        do_access(1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h1, 0, "load_illegal");
        do_access(0, 1, 3'b100, 32'h0000_1000, 32'h5, 32'h1, 0, "store_illegal");
        do_access(1, 1, 3'b010, 32'h0000_1000, 32'h5, 32'h1, 0, "read_and_write");
    endtask

    task automatic test_timeout;
        do_access(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, T, "timeout_load");
        do_access(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, T - 1, "last_cycle_ready");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 80; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            do_access(kind != 1, kind != 0, 3'($urandom), $urandom, $urandom, $urandom,
                      $urandom_range(0, T + 1), "random");
        end
    endtask

    task automatic test_reset_busy;
        bit seen;
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h0000_4000;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus_req;
        end
        rst = 1; mem_read = 0;
        #1;
        checks++;
        if (!seen || bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy abort: seen_req=%0d req=%b stall=%b, expected req=0 stall=0",
                     seen, bus_req, stall);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) rst = 0;
            checks++;
            if (done !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy quiet: done=%b req=%b, expected 0", done, bus_req);
            end
        end
        @(posedge clk);
        #1;
        do_access(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 0, "lw_after_reset");
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_byte_load;
        test_store;
        test_faults;
        test_timeout;
        test_back_to_back;
        test_reset_busy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
